alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_mul_seq.sv | 47 ++++
 rtl/alu.sv | 131 +++++++++++++
 tb/tb_alu.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode and controller state encodings,
// plus the default datapath width.
package alu_pkg;

  localparam int ALU_W_DEFAULT = 12;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_MUL   = 3'd2,
    OP_AND   = 3'd3,
    OP_OR    = 3'd4,
    OP_PASSB = 3'd5,
    OP_SHL   = 3'd6,
    OP_SHR   = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier: one multiplier bit per enabled cycle, N
// iterations, 2N-bit product. Only instantiated when ALU_MUL_EN is defined.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int N = ALU_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_i,
  input  logic           en_i,
  input  logic [N-1:0]   mcand_i,
  input  logic [N-1:0]   mplier_i,
  output logic [2*N-1:0] prod_o,
  output logic           last_o
);

  localparam int CW = $clog2(N + 1);

  logic [CW-1:0]  cnt_q;
  logic [N-1:0]   mcand_q;
  logic [2*N-1:0] prod_q;
  logic [N:0]     sum;

  // Multiplier sits in the low half and is consumed LSB-first as the
  // accumulating upper half shifts down into it.
  assign sum = {1'b0, prod_q[2*N-1:N]} + (prod_q[0] ? {1'b0, mcand_q} : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else if (load_i) begin
      cnt_q   <= CW'(N - 1);
      mcand_q <= mcand_i;
      prod_q  <= {{N{1'b0}}, mplier_i};
    end else if (en_i) begin
      prod_q <= {sum, prod_q[N-1:1]};
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign prod_o = prod_q;
  assign last_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/alu.sv
// Multi-cycle ALU with registered result and flags. Define ALU_MUL_EN to build
// the iterative multiplier; otherwise MUL reports an illegal-op result.
//
// state  | meaning
// IDLE   | waiting for start; operands/op captured on start
// EXEC   | result and flags registered from captured operands
// MUL    | shift-add iterations, one multiplier bit per cycle
// DONE   | done pulse issued, busy dropped, back to IDLE
module alu
  import alu_pkg::*;
#(
  parameter int N = ALU_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] alu_out,
  output logic         busy,
  output logic         done,
  output logic         z_flag,
  output logic         c_flag
);

  alu_state_e   state_q;
  alu_op_e      op_q;
  logic [N-1:0] a_q, b_q, alu_out_q;
  logic         z_q, c_q, busy_q, done_q;
  logic [N-1:0] res;
  logic         cout;
  logic         mul_last;

`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
  logic [2*N-1:0] mul_prod;

  alu_mul_seq #(.N(N)) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (state_q == S_IDLE && start && op == OP_MUL),
    .en_i     (state_q == S_MUL),
    .mcand_i  (a),
    .mplier_i (b),
    .prod_o   (mul_prod),
    .last_o   (mul_last)
  );
`else
  localparam bit MUL_EN = 1'b0;
  assign mul_last = 1'b0;
`endif

  always_comb begin
    res  = '0;
    cout = 1'b0;
    case (op_q)
      OP_ADD:   {cout, res} = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB:   {cout, res} = {1'b0, a_q} - {1'b0, b_q};
`ifdef ALU_MUL_EN
      OP_MUL: begin
        res  = mul_prod[N-1:0];
        cout = |mul_prod[2*N-1:N];
      end
`else
      // No multiplier: zero result with carry set flags the illegal op.
      OP_MUL: begin
        res  = '0;
        cout = 1'b1;
      end
`endif
      OP_AND:   res = a_q & b_q;
      OP_OR:    res = a_q | b_q;
      OP_PASSB: res = b_q;
      OP_SHL: begin
        res  = {a_q[N-2:0], 1'b0};
        cout = a_q[N-1];
      end
      OP_SHR: begin
        res  = {1'b0, a_q[N-1:1]};
        cout = a_q[0];
      end
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_ADD;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          a_q     <= a;
          b_q     <= b;
          op_q    <= alu_op_e'(op);
          busy_q  <= 1'b1;
          state_q <= (MUL_EN && op == OP_MUL) ? S_MUL : S_EXEC;
        end
        S_MUL: if (mul_last) state_q <= S_EXEC;
        S_EXEC: begin
          alu_out_q <= res;
          z_q       <= (res == '0);
          c_q       <= cout;
          state_q   <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign alu_out = alu_out_q;
  assign z_flag  = z_q;
  assign c_flag  = c_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed corner cases, randomized ops against an
// arithmetic reference model, ignored restarts and mid-operation reset.
module tb_alu;

  localparam int N = 12;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic [N-1:0] alu_out;
  logic         busy, done, z_flag, c_flag;

  int n_checks = 0;
  int n_fails  = 0;

  alu #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .alu_out (alu_out),
    .busy    (busy),
    .done    (done),
    .z_flag  (z_flag),
    .c_flag  (c_flag)
  );

  always #5 clk = ~clk;

  function automatic void model(input int o, input int av, input int bv,
                                output logic [N-1:0] er, output bit ez,
                                output bit ec, output int elat);
    int     m = 1 << N;
    int     r;
    longint p;
    r = 0; ec = 1'b0; elat = 2;
    case (o)
      0: begin r = (av + bv) % m; ec = (av + bv) >= m; end
      1: begin r = (av - bv + m) % m; ec = av < bv; end
      2: if (MUL_EN) begin
           p = longint'(av) * longint'(bv);
           r = int'(p % m); ec = p >= m; elat = N + 2;
         end else begin
           r = 0; ec = 1'b1;
         end
      3: r = av & bv;
      4: r = av | bv;
      5: r = bv;
      6: begin r = (av * 2) % m; ec = av >= (m / 2); end
      default: begin r = av / 2; ec = (av % 2) == 1; end
    endcase
    er = N'(r);
    ez = (r == 0);
  endfunction

  // Issues one operation and waits (bounded) for done; optionally re-pulses
  // start with junk operands while the operation is in flight.
  task automatic run_op(input int o, input int av, input int bv, input int exp_lat,
                        input bit repulse, output logic [N-1:0] r, output bit z,
                        output bit c, output int lat, output bit busy1);
    @(negedge clk);
    op = 3'(o); a = N'(av); b = N'(bv); start = 1'b1;
    @(posedge clk); #1;
    busy1 = busy;
    start = 1'b0; op = 3'($urandom_range(0, 7)); a = N'($urandom); b = N'($urandom);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (repulse && i < exp_lat) begin
        start = 1'b1; op = 3'($urandom_range(0, 7)); a = N'($urandom); b = N'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    start = 1'b0;
    r = alu_out; z = z_flag; c = c_flag;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_checks += 5;
    if (alu_out !== '0) begin n_fails++; $display("FAIL reset_alu_out got=%0d exp=0", alu_out); end
    if (z_flag !== 1'b0) begin n_fails++; $display("FAIL reset_z got=%b exp=0", z_flag); end
    if (c_flag !== 1'b0) begin n_fails++; $display("FAIL reset_c got=%b exp=0", c_flag); end
    if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin n_fails++; $display("FAIL reset_done got=%b exp=0", done); end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_directed();
    int ops[6] = '{0, 0, 1, 1, 2, 2};
    int as[6]  = '{2047, 4095, 5, 3, 100, 60};
    int bs[6]  = '{1, 1, 5, 5, 50, 50};
    logic [N-1:0] er, r;
    bit ez, ec, z, c, b1;
    int elat, lat;
    for (int i = 0; i < 6; i++) begin
      model(ops[i], as[i], bs[i], er, ez, ec, elat);
      run_op(ops[i], as[i], bs[i], elat, 1'b0, r, z, c, lat, b1);
      n_checks += 5;
      if (r !== er) begin n_fails++; $display("FAIL dir%0d_result got=%0d exp=%0d", i, r, er); end
      if (z !== ez) begin n_fails++; $display("FAIL dir%0d_z got=%b exp=%b", i, z, ez); end
      if (c !== ec) begin n_fails++; $display("FAIL dir%0d_c got=%b exp=%b", i, c, ec); end
      if (lat != elat) begin n_fails++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, elat); end
      if (b1 !== 1'b1) begin n_fails++; $display("FAIL dir%0d_busy got=%b exp=1", i, b1); end
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks += 2;
    if (alu_out !== er) begin n_fails++; $display("FAIL hold_result got=%0d exp=%0d", alu_out, er); end
    if (done !== 1'b0) begin n_fails++; $display("FAIL hold_done got=%b exp=0", done); end
  endtask

  task automatic test_random();
    logic [N-1:0] er, r;
    bit ez, ec, z, c, b1;
    int o, av, bv, elat, lat;
    for (int i = 0; i < 30; i++) begin
      o  = $urandom_range(0, 7);
      av = $urandom_range(0, (1 << N) - 1);
      bv = $urandom_range(0, (1 << N) - 1);
      if (i % 7 == 0) bv = av;
      model(o, av, bv, er, ez, ec, elat);
      run_op(o, av, bv, elat, 1'b0, r, z, c, lat, b1);
      n_checks += 4;
      if (r !== er) begin n_fails++; $display("FAIL rnd%0d_op%0d_result got=%0d exp=%0d", i, o, r, er); end
      if (z !== ez) begin n_fails++; $display("FAIL rnd%0d_op%0d_z got=%b exp=%b", i, o, z, ez); end
      if (c !== ec) begin n_fails++; $display("FAIL rnd%0d_op%0d_c got=%b exp=%b", i, o, c, ec); end
      if (lat != elat) begin n_fails++; $display("FAIL rnd%0d_op%0d_latency got=%0d exp=%0d", i, o, lat, elat); end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] er, r;
    bit ez, ec, z, c, b1;
    int elat, lat, extra;
    model(2, 100, 50, er, ez, ec, elat);
    run_op(2, 100, 50, elat, 1'b1, r, z, c, lat, b1);
    n_checks += 3;
    if (r !== er) begin n_fails++; $display("FAIL repulse_result got=%0d exp=%0d", r, er); end
    if (c !== ec) begin n_fails++; $display("FAIL repulse_c got=%b exp=%b", c, ec); end
    if (lat != elat) begin n_fails++; $display("FAIL repulse_latency got=%0d exp=%0d", lat, elat); end
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    n_checks++;
    if (extra != 0) begin n_fails++; $display("FAIL repulse_single_done got=%0d extra cycles exp=0", extra); end
  endtask

  task automatic test_reset_mid_op();
    logic [N-1:0] r;
    bit z, c, b1;
    int lat, dones;
    run_op(0, 7, 9, 2, 1'b0, r, z, c, lat, b1);
    @(negedge clk);
    op = 3'd2; a = N'(100); b = N'(50); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (MUL_EN ? 6 : 1) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks += 5;
    if (alu_out !== '0) begin n_fails++; $display("FAIL midrst_alu_out got=%0d exp=0", alu_out); end
    if (z_flag !== 1'b0) begin n_fails++; $display("FAIL midrst_z got=%b exp=0", z_flag); end
    if (c_flag !== 1'b0) begin n_fails++; $display("FAIL midrst_c got=%b exp=0", c_flag); end
    if (busy !== 1'b0) begin n_fails++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin n_fails++; $display("FAIL midrst_done got=%b exp=0", done); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    n_checks++;
    if (dones != 0) begin n_fails++; $display("FAIL midrst_no_done got=%0d active cycles exp=0", dones); end
    run_op(0, 1, 1, 2, 1'b0, r, z, c, lat, b1);
    n_checks += 3;
    if (r !== N'(2)) begin n_fails++; $display("FAIL post_rst_add got=%0d exp=2", r); end
    if (z !== 1'b0) begin n_fails++; $display("FAIL post_rst_z got=%b exp=0", z); end
    if (lat != 2) begin n_fails++; $display("FAIL post_rst_latency got=%0d exp=2", lat); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
